spi_ctrl_single_clk: RTL and testbench

SPI controller (master), mode 0 (CPOL=0, CPHA=0), MSB first by default. It is the initiator-side counterpart of the spi_single_clk peripheral, so the design can drive external SPI devices or loop back onto our own peripheral. Everything runs on sys_clk: sck is generated by a divider, and miso is sampled on the internal rising-edge strobe. A byte-wide valid/ready interface supplies transmit bytes; one received byte is reported per transmitted byte.

---
 rtl/spi_ctrl_single_clk_if.sv | 44 ++++
 rtl/spi_ctrl_single_clk.sv | 238 +++++++++++++++++++++++
 tb/tb_spi_ctrl_single_clk.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_ctrl_single_clk_if.sv
// ---------------------------------------------------------------------------
// spi_ctrl_single_clk_if
//
// Bundles the signals of the SPI controller, apart from the clock and reset:
// the byte stream interface and the SPI pads.
//
// Modports
//   master : the controller side. It drives tx_ready, rx_*, busy and the
//            csn/sck/mosi pads. It samples tx_* and miso_pad.
//   slave  : the environment side. It supplies transmit bytes and miso_pad,
//            and it observes everything else.
//
// Transmit handshake
//   A byte moves on every sys_clk rising edge where tx_valid && tx_ready are
//   both high. tx_data and tx_last are sampled together on that edge.
//   tx_valid may rise while tx_ready is low, but nothing is queued.
//   rx_valid is a one-cycle pulse with no back-pressure.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
interface spi_ctrl_single_clk_if #(
    parameter int BYTE_W = 8
);
    logic [BYTE_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_last;
    logic              tx_ready;
    logic [BYTE_W-1:0] rx_data;
    logic              rx_valid;
    logic              busy;
    logic              csn_pad;
    logic              sck_pad;
    logic              mosi_pad;
    logic              miso_pad;

    modport master (
        input  tx_data, tx_valid, tx_last, miso_pad,
        output tx_ready, rx_data, rx_valid, busy, csn_pad, sck_pad, mosi_pad
    );

    modport slave (
        output tx_data, tx_valid, tx_last, miso_pad,
        input  tx_ready, rx_data, rx_valid, busy, csn_pad, sck_pad, mosi_pad
    );
endinterface

// File: rtl/spi_ctrl_single_clk.sv
// ---------------------------------------------------------------------------
// spi_ctrl_single_clk
//
// SPI master in mode 0 (CPOL=0, CPHA=0). The whole design runs on sys_clk.
// A divider inside the design generates sck. miso is sampled on the same
// sys_clk edge that raises sck.
//
// Each byte accepted on the valid/ready interface is shifted out, and the
// byte received during that transfer is reported with a one-cycle rx_valid
// pulse. When tx_last is set on a byte, chip select is released after that
// byte. Otherwise chip select stays low and the controller waits in NEXT
// for the following byte.
//
// Ports
//   sys_clk     : system clock; all logic uses its rising edge
//   rst_n       : asynchronous reset, active low
//   bus         : spi_ctrl_single_clk_if.master, which carries the
//                 tx_data/tx_valid/tx_last/tx_ready inputs,
//                 rx_data/rx_valid/busy and the csn/sck/mosi/miso pads
//   dbg_state_o : current FSM state, for debug and checkers
//
// Optional feature
//   SPI_CTRL_LSB_FIRST_EN : when defined, bit 0 is sent first and the first
//                           received bit lands in rx_data[0]. The timing
//                           does not change.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module spi_ctrl_single_clk #(
    parameter int BYTE_W   = 8,
    parameter int CLK_DIV  = 6,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2
) (
    input  logic                        sys_clk,
    input  logic                        rst_n,
    spi_ctrl_single_clk_if.master       bus,
    output logic [2:0]                  dbg_state_o
);

    localparam int DIV_W  = $clog2(CLK_DIV + 1);
    localparam int SET_W  = $clog2(CS_SETUP + 1);
    localparam int HOLD_W = $clog2(CS_HOLD + 1);
    localparam int BIT_W  = $clog2(BYTE_W + 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_NEXT  = 3'd3,
        ST_HOLD  = 3'd4
    } state_e;

    // Bit-order helpers. These are the only places that depend on shift
    // direction. first_bit selects the bit that goes on the wire first.
    // shift_tx moves the next bit into that position. shift_rx appends one
    // sampled bit.
`ifdef SPI_CTRL_LSB_FIRST_EN
    function automatic logic first_bit(input logic [BYTE_W-1:0] d);
        return d[0];
    endfunction
    function automatic logic [BYTE_W-1:0] shift_tx(input logic [BYTE_W-1:0] d);
        return {1'b0, d[BYTE_W-1:1]};
    endfunction
    function automatic logic [BYTE_W-1:0] shift_rx(input logic [BYTE_W-1:0] r,
                                                   input logic b);
        return {b, r[BYTE_W-1:1]};
    endfunction
`else
    function automatic logic first_bit(input logic [BYTE_W-1:0] d);
        return d[BYTE_W-1];
    endfunction
    function automatic logic [BYTE_W-1:0] shift_tx(input logic [BYTE_W-1:0] d);
        return {d[BYTE_W-2:0], 1'b0};
    endfunction
    function automatic logic [BYTE_W-1:0] shift_rx(input logic [BYTE_W-1:0] r,
                                                   input logic b);
        return {r[BYTE_W-2:0], b};
    endfunction
`endif

    state_e              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [SET_W-1:0]    setup_q, setup_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [BYTE_W-1:0]   tx_sh_q, tx_sh_d;
    logic [BYTE_W-1:0]   rx_sh_q, rx_sh_d;
    logic [BYTE_W-1:0]   rx_data_q, rx_data_d;
    logic                rx_valid_q, rx_valid_d;
    logic                last_q, last_d;
    logic                csn_q, csn_d;
    logic                sck_q, sck_d;
    logic                mosi_q, mosi_d;

    logic                tx_ready;
    logic                accept;
    logic [BYTE_W-1:0]   tx_shifted;

    assign tx_ready   = (state_q == ST_IDLE) || (state_q == ST_NEXT);
    assign accept     = bus.tx_valid && tx_ready;
    assign tx_shifted = shift_tx(tx_sh_q);

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        setup_d    = setup_q;
        hold_d     = hold_q;
        bit_d      = bit_q;
        tx_sh_d    = tx_sh_q;
        rx_sh_d    = rx_sh_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        last_d     = last_q;
        csn_d      = csn_q;
        sck_d      = sck_q;
        mosi_d     = mosi_q;

        case (state_q)
            ST_IDLE: begin
                csn_d = 1'b1;
                sck_d = 1'b0;
                if (accept) begin
                    tx_sh_d = bus.tx_data;
                    mosi_d  = first_bit(bus.tx_data);
                    last_d  = bus.tx_last;
                    setup_d = '0;
                    bit_d   = '0;
                    csn_d   = 1'b0;
                    state_d = ST_SETUP;
                end
            end

            ST_SETUP: begin
                if (setup_q == SET_W'(CS_SETUP - 1)) begin
                    div_d   = '0;
                    state_d = ST_SHIFT;
                end else begin
                    setup_d = setup_q + 1'b1;
                end
            end

            ST_SHIFT: begin
                if (div_q == DIV_W'(CLK_DIV - 1)) begin
                    div_d = '0;
                    sck_d = ~sck_q;
                    if (!sck_q) begin
                        // Rising edge: sample miso and count the bit.
                        rx_sh_d = shift_rx(rx_sh_q, bus.miso_pad);
                        bit_d   = bit_q + 1'b1;
                    end else if (bit_q < BIT_W'(BYTE_W)) begin
                        // Falling edge inside the byte: present the next bit.
                        tx_sh_d = tx_shifted;
                        mosi_d  = first_bit(tx_shifted);
                    end else begin
                        // Falling edge after the last bit: the byte is
                        // done. mosi keeps its last value.
                        rx_data_d  = rx_sh_q;
                        rx_valid_d = 1'b1;
                        hold_d     = '0;
                        state_d    = last_q ? ST_HOLD : ST_NEXT;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end

            ST_NEXT: begin
                // Chip select stays low. There is no setup delay before a
                // back-to-back byte.
                if (accept) begin
                    tx_sh_d = bus.tx_data;
                    mosi_d  = first_bit(bus.tx_data);
                    last_d  = bus.tx_last;
                    bit_d   = '0;
                    div_d   = '0;
                    state_d = ST_SHIFT;
                end
            end

            ST_HOLD: begin
                if (hold_q == HOLD_W'(CS_HOLD - 1)) begin
                    csn_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end

            default: begin
                csn_d   = 1'b1;
                sck_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            div_q      <= '0;
            setup_q    <= '0;
            hold_q     <= '0;
            bit_q      <= '0;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            last_q     <= 1'b0;
            csn_q      <= 1'b1;
            sck_q      <= 1'b0;
            mosi_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            setup_q    <= setup_d;
            hold_q     <= hold_d;
            bit_q      <= bit_d;
            tx_sh_q    <= tx_sh_d;
            rx_sh_q    <= rx_sh_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            last_q     <= last_d;
            csn_q      <= csn_d;
            sck_q      <= sck_d;
            mosi_q     <= mosi_d;
        end
    end

    assign bus.tx_ready = tx_ready;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.busy     = (state_q != ST_IDLE);
    assign bus.csn_pad  = csn_q;
    assign bus.sck_pad  = sck_q;
    assign bus.mosi_pad = mosi_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_spi_ctrl_single_clk.sv
`timescale 1ns/1ps
module tb_spi_ctrl_single_clk;

  localparam int  BYTE_W   = 8;
  localparam int  CLK_DIV  = 6;
  localparam int  CS_SETUP = 2;
  localparam int  CS_HOLD  = 2;
  localparam time T_CLK    = 20;

  // ---------------- clock / reset ----------------
  logic       sys_clk = 1'b0;
  logic       rst_n   = 1'b0;
  logic [2:0] dbg_state;

  always #(T_CLK / 2) sys_clk = ~sys_clk;

  spi_ctrl_single_clk_if #(.BYTE_W(BYTE_W)) bus ();

  spi_ctrl_single_clk #(
    .BYTE_W  (BYTE_W),
    .CLK_DIV (CLK_DIV),
    .CS_SETUP(CS_SETUP),
    .CS_HOLD (CS_HOLD)
  ) dut (
    .sys_clk    (sys_clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .dbg_state_o(dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- slave model / loopback ----------------
  logic              lb;
  logic [BYTE_W-1:0] slave_q[$];
  logic [BYTE_W-1:0] slave_cur;
  int                slave_bits;
  logic              slave_bit;

`ifdef SPI_CTRL_LSB_FIRST_EN
  assign slave_bit = slave_cur[slave_bits];
`else
  assign slave_bit = slave_cur[BYTE_W-1-slave_bits];
`endif
  assign bus.miso_pad = lb ? bus.mosi_pad : slave_bit;

  task automatic slave_load(input logic [BYTE_W-1:0] first);
    slave_q.delete();
    slave_cur  = first;
    slave_bits = 0;
  endtask

  // ---------------- monitors ----------------
  int                rise_cnt;
  time               rise_t[$];
  logic              mosi_bits[$];
  int                csn_viol;
  int                csn_rises;
  time               last_fall_t;
  time               csn_rise_t;
  time               csn_fall_t;
  logic [BYTE_W-1:0] rx_got[$];
  logic              prev_rv = 1'b0;
  int                rv_wide;
  int                next_ready_cnt;
  logic [BYTE_W-1:0] exp_q[$];     // expected received bytes
  logic [BYTE_W-1:0] exp_tx_q[$];  // bytes that should appear on mosi

  always @(posedge bus.sck_pad) begin
    rise_cnt++;
    rise_t.push_back($time);
    mosi_bits.push_back(bus.mosi_pad);
    if (bus.csn_pad !== 1'b0) csn_viol++;
  end

  always @(negedge bus.sck_pad) begin
    last_fall_t = $time;
    slave_bits++;
    if (slave_bits == BYTE_W) begin
      slave_bits = 0;
      slave_cur  = (slave_q.size() > 0) ? slave_q.pop_front() : '0;
    end
  end

  always @(posedge bus.csn_pad) begin
    csn_rise_t = $time;
    csn_rises++;
  end

  always @(negedge bus.csn_pad) csn_fall_t = $time;

  always @(negedge sys_clk) begin
    if (bus.rx_valid === 1'b1) begin
      rx_got.push_back(bus.rx_data);
      if (prev_rv) rv_wide++;
    end
    prev_rv = bus.rx_valid;
    if (bus.tx_ready === 1'b1 && bus.busy === 1'b1) next_ready_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic clear_mon();
    rise_cnt = 0; rise_t.delete(); mosi_bits.delete(); rx_got.delete();
    exp_q.delete(); exp_tx_q.delete();
    csn_viol = 0; csn_rises = 0; rv_wide = 0; next_ready_cnt = 0;
  endtask

  task automatic push(input logic [BYTE_W-1:0] d, input logic last);
    @(negedge sys_clk);
    bus.tx_data  = d;
    bus.tx_last  = last;
    bus.tx_valid = 1'b1;
    for (int i = 0; i < 5000 && bus.tx_ready !== 1'b1; i++) @(negedge sys_clk);
    check("accept_ready", bus.tx_ready, 1'b1);
    exp_tx_q.push_back(d);
    @(posedge sys_clk);
  endtask

  task automatic drop();
    @(negedge sys_clk);
    bus.tx_valid = 1'b0;
    bus.tx_data  = BYTE_W'($urandom);
    bus.tx_last  = 1'($urandom);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 5000 && bus.busy !== 1'b0; i++) @(negedge sys_clk);
    check(tag, bus.busy, 1'b0);
  endtask

  // The scoreboard compares the bytes received against exp_q. It also
  // rebuilds each byte from the mosi bits seen at sck rising edges, in wire
  // order.
  task automatic score(input string tag);
    logic [BYTE_W-1:0] v;
    check({tag, "_rx_count"}, rx_got.size(), exp_q.size());
    for (int b = 0; b < exp_q.size() && b < rx_got.size(); b++)
      check({tag, "_rx_data"}, rx_got[b], exp_q[b]);
    check({tag, "_mosi_bits"}, mosi_bits.size(), BYTE_W * exp_tx_q.size());
    for (int b = 0; b < exp_tx_q.size() && (b + 1) * BYTE_W <= mosi_bits.size(); b++) begin
      v = '0;
      for (int k = 0; k < BYTE_W; k++)
`ifdef SPI_CTRL_LSB_FIRST_EN
        v[k] = mosi_bits[b*BYTE_W + k];
`else
        v[BYTE_W-1-k] = mosi_bits[b*BYTE_W + k];
`endif
      check({tag, "_mosi_byte"}, v, exp_tx_q[b]);
    end
    check({tag, "_rv_width"}, rv_wide, 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2ms;
    $display("FAIL watchdog expired before end of sequence");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [BYTE_W-1:0] d, r;
    int n, stall_viol;

    bus.tx_valid = 1'b0;
    bus.tx_data  = '0;
    bus.tx_last  = 1'b0;
    lb = 1'b1;
    slave_load('0);
    clear_mon();

    // Reset values
    repeat (3) @(negedge sys_clk);
    check("rst_csn", bus.csn_pad, 1'b1);
    check("rst_sck", bus.sck_pad, 1'b0);
    check("rst_mosi", bus.mosi_pad, 1'b0);
    check("rst_rx_data", bus.rx_data, '0);
    check("rst_rx_valid", bus.rx_valid, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_tx_ready", bus.tx_ready, 1'b1);
    rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);
    check("post_rst_csn", bus.csn_pad, 1'b1);
    check("post_rst_ready", bus.tx_ready, 1'b1);

    // Single byte A5 in loopback
    clear_mon();
    push(8'hA5, 1'b1); exp_q.push_back(8'hA5);
    drop();
    wait_idle("a5_idle");
    check("a5_rises", rise_cnt, 8);
    for (int i = 1; i < rise_t.size(); i++)
      check("a5_sck_period", 32'(rise_t[i] - rise_t[i-1]), 32'(2 * CLK_DIV * T_CLK));
    check("a5_csn_low", csn_viol, 0);
    check("a5_setup_min", 32'((rise_t.size() > 0) && (rise_t[0] - csn_fall_t >= CS_SETUP * T_CLK)), 1);
    check("a5_hold", 32'(csn_rise_t - last_fall_t), 32'(CS_HOLD * T_CLK));
    check("a5_csn_end", bus.csn_pad, 1'b1);
    score("a5");

    // Three-byte burst with tx_valid held high
    clear_mon();
    push(8'h01, 1'b0); exp_q.push_back(8'h01);
    push(8'h80, 1'b0); exp_q.push_back(8'h80);
    push(8'hFF, 1'b1); exp_q.push_back(8'hFF);
    drop();
    wait_idle("burst_idle");
    check("burst_rises", rise_cnt, 24);
    check("burst_csn_low", csn_viol, 0);
    check("burst_csn_rises", csn_rises, 1);
    check("burst_next_ready", next_ready_cnt, 2);
    score("burst");

    // Stall in NEXT for 100 cycles
    clear_mon();
    d = BYTE_W'($urandom);
    push(d, 1'b0); exp_q.push_back(d);
    drop();
    for (int i = 0; i < 5000 && !(bus.tx_ready === 1'b1 && bus.busy === 1'b1); i++)
      @(negedge sys_clk);
    stall_viol = 0;
    for (int i = 0; i < 100; i++) begin
      if (bus.sck_pad !== 1'b0 || bus.csn_pad !== 1'b0 || bus.tx_ready !== 1'b1) stall_viol++;
      @(negedge sys_clk);
    end
    check("stall_hold", stall_viol, 0);
    d = BYTE_W'($urandom);
    push(d, 1'b1); exp_q.push_back(d);
    drop();
    wait_idle("stall_idle");
    score("stall");

    // Slave model returns 3C while C3 is sent
    lb = 1'b0;
    clear_mon();
    slave_load(8'h3C);
    push(8'hC3, 1'b1); exp_q.push_back(8'h3C);
    drop();
    wait_idle("model_idle");
    score("model");

    // Random multi-byte transactions against the slave model
    for (int t = 0; t < 4; t++) begin
      clear_mon();
      n = $urandom_range(1, 3);
      for (int b = 0; b < n; b++) begin
        r = BYTE_W'($urandom);
        if (b == 0) slave_load(r); else slave_q.push_back(r);
        exp_q.push_back(r);
      end
      for (int b = 0; b < n; b++) begin
        d = BYTE_W'($urandom);
        push(d, (b == n - 1));
        if ($urandom_range(0, 1) == 1) begin
          drop();
          repeat ($urandom_range(1, 150)) @(negedge sys_clk);
        end
      end
      drop();
      wait_idle("rand_idle");
      check("rand_rises", rise_cnt, BYTE_W * n);
      check("rand_csn_low", csn_viol, 0);
      score("rand");
    end

    // Reset in the middle of a byte
    lb = 1'b1;
    clear_mon();
    push(8'hFF, 1'b1);
    drop();
    for (int i = 0; i < 5000 && rise_cnt < 4; i++) @(negedge sys_clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_csn", bus.csn_pad, 1'b1);
    check("abort_sck", bus.sck_pad, 1'b0);
    check("abort_mosi", bus.mosi_pad, 1'b0);
    check("abort_busy", bus.busy, 1'b0);
    repeat (3) @(negedge sys_clk);
    check("abort_no_rx", rx_got.size(), 0);
    rst_n = 1'b1;
    @(negedge sys_clk);
    clear_mon();
    push(8'h5A, 1'b1); exp_q.push_back(8'h5A);
    drop();
    wait_idle("after_abort_idle");
    score("after_abort");

    // First bit on the wire for 01 (depends on bit order)
    clear_mon();
    push(8'h01, 1'b1); exp_q.push_back(8'h01);
    drop();
    wait_idle("first_bit_idle");
`ifdef SPI_CTRL_LSB_FIRST_EN
    check("first_bit", (mosi_bits.size() > 0) ? mosi_bits[0] : 1'bx, 1'b1);
`else
    check("first_bit", (mosi_bits.size() > 0) ? mosi_bits[0] : 1'bx, 1'b0);
`endif
    score("first_bit");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
